// File: rtl/vape_exec_reporter_pkg.sv
// Shared types and constants for the VAPE exec reporter: FSM states, register
// offsets, STATUS bit positions, CTRL bits and the {cause, pc} log entry layout.
package vape_exec_reporter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } vape_state_t;

    localparam logic [2:0] OFF_STATUS   = 3'd0;
    localparam logic [2:0] OFF_VIOLCNT  = 3'd1;
    localparam logic [2:0] OFF_LOGCAUSE = 3'd2;
    localparam logic [2:0] OFF_LOGPC    = 3'd3;
    localparam logic [2:0] OFF_CTRL     = 3'd4;

    localparam int ST_BIT_EXEC   = 0;
    localparam int ST_BIT_PROOF  = 1;
    localparam int ST_BIT_STICKY = 2;
    localparam int ST_BIT_OVF    = 3;
    localparam int ST_LSB_COUNT  = 4;
    localparam int ST_LSB_STATE  = 8;

    localparam int CTRL_BIT_CLEAR = 0;
    localparam int CTRL_BIT_FLUSH = 1;

    localparam int CAUSE_W = 5;
    localparam int ENTRY_W = 21;

    // Cause bit i is set when exec(i+1) was low in the violation cycle.
    typedef struct packed {
        logic [CAUSE_W-1:0] cause;
        logic [15:0]        pc;
    } viol_entry_t;

endpackage

// File: rtl/vape_exec_reporter_if.sv
// openMSP430 peripheral bus slice used by the VAPE exec reporter.
interface vape_exec_reporter_if;
    logic        per_en;
    logic [1:0]  per_we;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic [15:0] per_dout;

    modport master (output per_en, output per_we, output per_addr, output per_din, input per_dout);
    modport slave  (input per_en, input per_we, input per_addr, input per_din, output per_dout);
endinterface

// File: rtl/vape_viol_fifo.sv
// Violation log FIFO: LOG_DEPTH entries of {cause, pc}; flush beats push,
// a push into a full FIFO succeeds only when a pop frees a slot in the same cycle.
module vape_viol_fifo
    import vape_exec_reporter_pkg::*;
#(
    parameter int LOG_DEPTH = 4,
    localparam int PTR_W = $clog2(LOG_DEPTH),
    localparam int CNT_W = $clog2(LOG_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  viol_entry_t      din,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output viol_entry_t      head
);

    viol_entry_t            mem [LOG_DEPTH];
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_ptr;
    logic                   do_push;
    logic                   do_pop;

    assign full    = (count == CNT_W'(LOG_DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < LOG_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vape_exec_reporter.sv
// VAPE exec reporter: run-state FSM, violation log/counter and peripheral register window.
// Optional interrupt on a non-empty log is built when VAPE_REPORT_IRQ_EN is defined.
module vape_exec_reporter
    import vape_exec_reporter_pkg::*;
#(
    parameter logic [13:0] BASE_ADDR = 14'h0090,
    parameter int          LOG_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           pc,
    input  logic [15:0]           ER_min,
    input  logic [15:0]           ER_max,
    input  logic                  exec,
    input  logic [4:0]            exec_sub,
    vape_exec_reporter_if.slave   bus,
    output logic                  irq_viol
);

    localparam int CNT_W = $clog2(LOG_DEPTH) + 1;

    vape_state_t      state;
    logic             exec_q;
    logic             viol;
    logic             start;
    logic             proof_valid;
    logic [15:0]      viol_cnt;
    logic             sticky_viol;
    logic             overflow;

    logic [13:0]      addr_off;
    logic [2:0]       off;
    logic             sel;
    logic             rd;
    logic             wr;
    logic             pop_req;
    logic             clear;
    logic             flush;

    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    viol_entry_t      fifo_head;
    viol_entry_t      new_entry;
    logic [15:0]      rdata;
    logic             unused_din;

    assign viol        = exec_q & ~exec;
    assign start       = ~exec_q & exec;
    assign proof_valid = (state == ST_DONE) & exec;

    // Window hit is taken from the offset so BASE_ADDR need not be 8-aligned.
    assign addr_off   = bus.per_addr - BASE_ADDR;
    assign off        = addr_off[2:0];
    assign sel        = bus.per_en & (addr_off[13:3] == '0);
    assign rd         = sel & (bus.per_we == 2'b00);
    assign wr         = sel & (bus.per_we != 2'b00);
    assign pop_req    = rd & (off == OFF_LOGPC);
    assign clear      = wr & (off == OFF_CTRL) & bus.per_din[CTRL_BIT_CLEAR];
    assign flush      = wr & (off == OFF_CTRL) & bus.per_din[CTRL_BIT_FLUSH];
    assign unused_din = ^bus.per_din[15:2];

    assign new_entry.cause = ~exec_sub;
    assign new_entry.pc    = pc;

    vape_viol_fifo #(.LOG_DEPTH(LOG_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (viol),
        .pop   (pop_req),
        .flush (flush),
        .din   (new_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .head  (fifo_head)
    );

    // A violation overrides every other transition in its cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            exec_q <= 1'b0;
        end else begin
            exec_q <= exec;
            if (viol) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE:  if (start) state <= ST_ARMED;
                    ST_ARMED: if (exec && (pc == ER_min)) state <= ST_RUN;
                    ST_RUN:   if (exec && (pc == ER_max)) state <= ST_DONE;
                    ST_DONE:  if (start) state <= ST_ARMED;
                    default:  state <= ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            viol_cnt    <= '0;
            sticky_viol <= 1'b0;
            overflow    <= 1'b0;
        end else if (clear) begin
            viol_cnt    <= '0;
            sticky_viol <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (viol) begin
                sticky_viol <= 1'b1;
                if (viol_cnt != 16'hFFFF) viol_cnt <= viol_cnt + 16'd1;
            end
            if (viol && !flush && fifo_full && !pop_req) overflow <= 1'b1;
        end
    end

    always_comb begin
        rdata = '0;
        if (rd) begin
            case (off)
                OFF_STATUS: begin
                    rdata[ST_BIT_EXEC]                  = exec;
                    rdata[ST_BIT_PROOF]                 = proof_valid;
                    rdata[ST_BIT_STICKY]                = sticky_viol;
                    rdata[ST_BIT_OVF]                   = overflow;
                    rdata[ST_LSB_COUNT +: 4]            = 4'(fifo_count);
                    rdata[ST_LSB_STATE +: 2]            = state;
                end
                OFF_VIOLCNT:  rdata = viol_cnt;
                OFF_LOGCAUSE: rdata[CAUSE_W-1:0] = fifo_head.cause;
                OFF_LOGPC:    rdata = fifo_head.pc;
                default:      rdata = '0;
            endcase
        end
    end

    assign bus.per_dout = rdata;

`ifdef VAPE_REPORT_IRQ_EN
    logic nonempty_next;

    // Registered from the FIFO's next occupancy so irq tracks the log with no extra lag.
    assign nonempty_next = ~flush & (viol | (fifo_count > CNT_W'(1)) | (~fifo_empty & ~pop_req));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq_viol <= 1'b0;
        else        irq_viol <= nonempty_next;
    end
`else
    assign irq_viol = 1'b0;
`endif

endmodule
